pwm_fade_ctrl: RTL and testbench

Upstream duty-cycle sequencer for the LED PWM stage. It produces a "breathing" duty value that ramps up, holds, ramps down and holds again. The duty value is expressed in PWM counter units (0..DUTY_MAX, where DUTY_MAX is the PWM period length). Updates occur only at PWM period boundaries, signalled by period_tick from the PWM stage, so the consumer never sees a mid-period duty change.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_fade_ctrl_tick_counter.sv | 18 +
 rtl/pwm_fade_ctrl.sv | 88 ++++++++
 tb/tb_pwm_fade_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: state codes and duty defaults shared by the PWM fade path and the PWM stage.
package pwm_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } fade_state_t;
    localparam int DUTY_W_DEF   = 8;
    localparam int DUTY_MAX_DEF = 100;
endpackage

// File: rtl/pwm_fade_ctrl_tick_counter.sv
// tick_counter: modulo counter that advances only on qualified ticks and flags its final count.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         last
);
    logic [W-1:0] cnt_q, cnt_d;
    assign last = cnt_q == limit;
    always_comb cnt_d = clr ? '0 : !tick ? cnt_q : last ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: breathing duty sequencer (ramp up, hold, ramp down, hold) advanced on PWM period ticks.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W         = DUTY_W_DEF,
    parameter int DUTY_MAX       = DUTY_MAX_DEF,
    parameter int STEP           = 1,
    parameter int TICKS_PER_STEP = 4,
    parameter int HOLD_PERIODS   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              period_tick,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic [2:0]        state,
    output logic              cycle_done
);
    localparam int SW = $clog2(TICKS_PER_STEP + 1);
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    fade_state_t state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_up, duty_dn;
    logic [DUTY_W:0] sum;
    logic duty_update_q, duty_update_d, cycle_done_q, cycle_done_d;
    logic step_last, hold_last, step_clr, hold_clr, ramp, hold, valid;
    tick_counter #(.W(SW)) u_step (
        .clk(clk), .reset(reset), .clr(step_clr), .tick(period_tick),
        .limit(SW'(TICKS_PER_STEP - 1)), .last(step_last)
    );
    tick_counter #(.W(HW)) u_hold (
        .clk(clk), .reset(reset), .clr(hold_clr), .tick(period_tick),
        .limit(HW'(HOLD_PERIODS - 1)), .last(hold_last)
    );
    always_comb begin
        ramp = state_q == RAMP_UP || state_q == RAMP_DOWN;
        hold = state_q == HOLD_HI || state_q == HOLD_LO;
        valid = ramp || hold || state_q == IDLE;
        // counters only run in the states that own them, so every entry starts from zero
        step_clr = !enable || !ramp;
        hold_clr = !enable || !hold;
        sum = {1'b0, duty_q} + (DUTY_W + 1)'(STEP);
        duty_up = sum > (DUTY_W + 1)'(DUTY_MAX) ? DUTY_W'(DUTY_MAX) : sum[DUTY_W-1:0];
        duty_dn = duty_q < DUTY_W'(STEP) ? '0 : duty_q - DUTY_W'(STEP);
        state_d = state_q;
        duty_d = duty_q;
        cycle_done_d = 1'b0;
        if (!enable || !valid) begin
            state_d = IDLE;
            duty_d = '0;
        end else if (period_tick) begin
            case (state_q)
                IDLE: state_d = RAMP_UP;
                RAMP_UP: if (step_last) begin
                    duty_d = duty_up;
                    state_d = duty_up == DUTY_W'(DUTY_MAX) ? HOLD_HI : RAMP_UP;
                end
                HOLD_HI: state_d = hold_last ? RAMP_DOWN : HOLD_HI;
                RAMP_DOWN: if (step_last) begin
                    duty_d = duty_dn;
                    state_d = duty_dn == '0 ? HOLD_LO : RAMP_DOWN;
                end
                HOLD_LO: if (hold_last) begin
                    state_d = RAMP_UP;
                    cycle_done_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        duty_update_d = duty_d != duty_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            duty_q <= '0;
            duty_update_q <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q <= duty_d;
            duty_update_q <= duty_update_d;
            cycle_done_q <= cycle_done_d;
        end
    assign duty = duty_q;
    assign duty_update = duty_update_q;
    assign state = state_q;
    assign cycle_done = cycle_done_q;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: three differently parameterised instances checked every cycle against a tick-indexed breathing profile.
module tb_pwm_fade_ctrl;
    localparam int ST [3] = '{25, 30, 25};
    localparam int TP [3] = '{2, 1, 1};
    localparam int HP [3] = '{3, 2, 1};
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic tick [3];
    logic [7:0] duty_o [3];
    logic [2:0] st_o [3];
    logic dup_o [3];
    logic cd_o [3];
    int pd [3][64];
    int ps [3][64];
    bit pc [3][64];
    int plen [3];
    int n [3];
    int e_duty [3];
    int e_st [3];
    bit e_dup [3];
    bit e_cd [3];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pwm_fade_ctrl #(
            .DUTY_W(8), .DUTY_MAX(100), .STEP(ST[g]),
            .TICKS_PER_STEP(TP[g]), .HOLD_PERIODS(HP[g])
        ) u_dut (
            .clk(clk), .reset(reset), .enable(enable), .period_tick(tick[g]),
            .duty(duty_o[g]), .duty_update(dup_o[g]), .state(st_o[g]), .cycle_done(cd_o[g])
        );
    end
    task automatic add(input int g, input int s, input int d, input bit c);
        ps[g][plen[g]] = s;
        pd[g][plen[g]] = d;
        pc[g][plen[g]] = c;
        plen[g]++;
    endtask
    // entry k = (state, duty, cycle_done) after tick k+1 since enable; entries 1.. repeat forever
    task automatic build(input int g);
        int v = 0;
        add(g, 1, 0, 0);
        while (v < 100) begin
            repeat (TP[g] - 1) add(g, 1, v, 0);
            v = (v + ST[g] > 100) ? 100 : v + ST[g];
            add(g, v == 100 ? 2 : 1, v, 0);
        end
        repeat (HP[g] - 1) add(g, 2, v, 0);
        add(g, 3, v, 0);
        while (v > 0) begin
            repeat (TP[g] - 1) add(g, 3, v, 0);
            v = (v < ST[g]) ? 0 : v - ST[g];
            add(g, v == 0 ? 4 : 3, v, 0);
        end
        repeat (HP[g] - 1) add(g, 4, 0, 0);
        add(g, 1, 0, 1);
    endtask
    task automatic check(input int g, input string tag);
        logic [11:0] obs, exp;
        obs = {st_o[g], duty_o[g], dup_o[g], cd_o[g]};
        exp = {3'(e_st[g]), 8'(e_duty[g]), e_dup[g], e_cd[g]};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d state/duty/update/done observed=%0d/%0d/%0b/%0b expected=%0d/%0d/%0b/%0b",
                   tag, g, st_o[g], duty_o[g], dup_o[g], cd_o[g], e_st[g], e_duty[g], e_dup[g], e_cd[g]);
        end
    endtask
    task automatic clear_model();
        for (int g = 0; g < 3; g++) begin
            n[g] = 0;
            e_duty[g] = 0;
            e_st[g] = 0;
            e_dup[g] = 1'b0;
            e_cd[g] = 1'b0;
        end
    endtask
    task automatic step(input string tag);
        for (int g = 0; g < 3; g++) begin
            int idx;
            if (reset) begin
                n[g] = 0;
                e_duty[g] = 0;
                e_st[g] = 0;
                e_dup[g] = 1'b0;
                e_cd[g] = 1'b0;
            end else if (!enable) begin
                n[g] = 0;
                e_dup[g] = e_duty[g] != 0;
                e_duty[g] = 0;
                e_st[g] = 0;
                e_cd[g] = 1'b0;
            end else if (tick[g]) begin
                n[g]++;
                idx = n[g] == 1 ? 0 : 1 + (n[g] - 2) % (plen[g] - 1);
                e_dup[g] = pd[g][idx] != e_duty[g];
                e_duty[g] = pd[g][idx];
                e_st[g] = ps[g][idx];
                e_cd[g] = pc[g][idx];
            end else begin
                e_dup[g] = 1'b0;
                e_cd[g] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) check(g, tag);
    endtask
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        clear_model();
        for (int g = 0; g < 3; g++) check(g, tag);
        step(tag);
        reset = 1'b0;
    endtask
    task automatic paced(input int i);
        tick[0] = (i % 10) == 0;
        tick[1] = (i % 10) == 0;
        tick[2] = 1'b1;
    endtask
    initial begin
        bit found;
        for (int g = 0; g < 3; g++) begin
            tick[g] = 1'b0;
            plen[g] = 0;
            build(g);
        end
        clear_model();
        #2 reset = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) check(g, "reset_no_clk");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < 3; g++) tick[g] = i[0];
            step("disabled_ticks");
        end
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            paced(i);
            step("full_cycle");
        end
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            paced(i);
            step("to_duty50");
            found = e_st[0] == 1 && e_duty[0] == 50;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_duty50 observed=not_reached expected=reached");
        end
        enable = 1'b0;
        step("enable_drop");
        enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            paced(i);
            step("re_enable");
        end
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            paced(i);
            step("to_hold_hi");
            found = e_st[0] == 2;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_hold_hi observed=not_reached expected=reached");
        end
        async_reset("reset_hold_hi");
        for (int i = 0; i < 300; i++) begin
            paced(i);
            step("resume");
        end
        for (int i = 0; i < 3000; i++) begin
            tick[0] = $urandom_range(0, 2) == 0;
            tick[1] = $urandom_range(0, 1) == 0;
            tick[2] = $urandom_range(0, 7) != 0;
            enable = $urandom_range(0, 79) != 0;
            if ($urandom_range(0, 299) == 0) async_reset("random_reset");
            else step("random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
